wb_stage: RTL and testbench
===========================

# wb_stage

Write-back stage of the MIPS pipeline: registers the MEM/WB bundle, selects the result (ALU, load data, link address), performs big-endian load byte/halfword extraction with sign/zero extension, and drives the register bank write port. Writes to register 0 and misaligned loads are suppressed. A retired-instruction counter is maintained. It sits directly upstream of the register bank and consumes the memory stage's outputs.

## Interface
- DW, 32, data/address width
- AW, 5, register address width
- clk  in  1  rising-edge clock
- R  in  1  reset: synchronous, active-high
- stall  in  1  hold current WB entry; input bundle ignored
- flush  in  1  load a bubble instead of the input bundle
- in_valid  in  1  input bundle valid
- in_regwrite  in  1  instruction writes a register
- in_rd  in  AW  destination register
- in_sel  in  2  result select: 00 ALU, 01 load, 10 link (PC+8), 11 treated as ALU
- in_ldtype  in  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu; others treated as lw
- in_alu  in  DW  ALU result; load byte address when in_sel=01
- in_mem  in  DW  raw data-memory word
- in_pc  in  DW  instruction PC
- AdrC  out  AW  register bank write address
- C  out  DW  register bank write data
- W  out  1  register bank write enable
- misalign  out  1  one-cycle pulse: captured load misaligned, write dropped
- retired  out  32  count of valid entries completed

## Operation
- Stage register fields: valid, regwrite, rd, sel, ldtype, alu, mem, pc, plus flag `done`.
- Load priority: R > flush > stall > normal capture.
- R: clears all fields and `retired`; AdrC=0, C=0, W=0, misalign=0.
- flush (R=0): valid←0, done←0.
- stall (R=0, flush=0): fields hold; done←1 if valid.
- Normal: capture input bundle, done←0.
- Load extraction, big-endian, offset = alu[1:0]: byte k → mem[31-8k:24-8k]; halfword alu[1]=0 → mem[31:16], alu[1]=1 → mem[15:0]; lb/lh sign-extend, lbu/lhu zero-extend to DW.
- Misaligned: lh/lhu with alu[0]=1, lw with alu[1:0]≠00.
- Link result: pc+8, modulo 2^DW.
- W = valid & regwrite & (rd≠0) & ~done & ~misaligned-load; AdrC = rd; C = selected result. When W=0, AdrC and C still reflect the entry (don't-care to consumers).
- misalign = valid & ~done & misaligned-load & regwrite.
- retired increments by 1 for every entry with valid=1 and done=0, whether or not it writes; wraps 0xFFFFFFFF→0.

## Timing
- Latency: input bundle sampled at edge N; AdrC/C/W valid from edge N to edge N+1 (combinational from stage register).
- A stalled entry presents W exactly once (first cycle); held cycles show W=0, retired unchanged.
- flush and stall together: flush wins, bubble loaded.
- R asserted mid-stall: entry discarded, no write on the following cycle.
- Back-to-back writes to same rd: each presented in its own cycle, program order.

## Configuration
- WB_FWD_EN defined: adds outputs fwd_valid (1), fwd_adr (AW), fwd_data (DW), equal to W, AdrC, C but fwd_valid stays high during held (done=1) stall cycles, for the decode stage's bypass; reset 0.
- Undefined: ports absent, no bypass logic.

## Structure
- Shared package: result-select codes, load-type codes, DW/AW defaults, LINK_OFFSET=8.
- Sub-module load_align: combinational extraction + extension + misalign detect from (ldtype, alu[1:0], mem).

## Test plan
- R=1 for 2 cycles then release -> AdrC=0, C=0, W=0, retired=0.
- ALU result 0x12345678 to rd=5, regwrite=1 -> next cycle W=1, AdrC=5, C=0x12345678; retired=1.
- lb, alu=0x...1, mem=0x11F23344 -> C=0xFFFFFFF2; lbu same -> C=0x000000F2; lhu alu[1]=1, mem=0x0000ABCD -> C=0x0000ABCD.
- lw with alu=0x1002 -> W=0, misalign pulses 1 cycle; rd=0 ALU write -> W=0, retired still increments.
- Capture link entry pc=0x00400010, rd=31, then stall 3 cycles -> W=1 once with C=0x00400018, then W=0 for held cycles; retired +1 only.
- flush and stall asserted with valid input -> W=0 next cycle; retired=0xFFFFFFFF plus one valid entry -> retired=0.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared definitions for the write-back stage.
//   DW/AW        default data and register-address widths
//   sel_e        result-select codes
//   ldtype_e     load-type codes (unlisted codes behave as lw)
//   LINK_OFFSET  link address distance from the instruction PC
//   wb_entry_t   MEM/WB stage register payload
package wb_stage_pkg;

  localparam int unsigned DW          = 32;
  localparam int unsigned AW          = 5;
  localparam int unsigned LINK_OFFSET = 8;

  typedef enum logic [1:0] {
    SEL_ALU  = 2'b00,
    SEL_LOAD = 2'b01,
    SEL_LINK = 2'b10,
    SEL_ALT  = 2'b11
  } sel_e;

  typedef enum logic [2:0] {
    LD_W  = 3'b000,
    LD_H  = 3'b001,
    LD_HU = 3'b010,
    LD_B  = 3'b011,
    LD_BU = 3'b100
  } ldtype_e;

  typedef struct packed {
    logic          valid;
    logic          regwrite;
    logic [AW-1:0] rd;
    logic [1:0]    sel;
    logic [2:0]    ldtype;
    logic [DW-1:0] alu;
    logic [DW-1:0] mem;
    logic [DW-1:0] pc;
  } wb_entry_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// load_align: big-endian byte/halfword extraction from a memory word,
// sign/zero extension to DW, and misalignment detection.
//   ldtype     in  load type code
//   off        in  byte offset (address bits [1:0])
//   mem        in  raw data-memory word
//   data       out extracted and extended load value
//   misaligned out halfword on odd address or word on non-zero offset
module load_align
  import wb_stage_pkg::*;
(
  input  logic [2:0]    ldtype,
  input  logic [1:0]    off,
  input  logic [DW-1:0] mem,
  output logic [DW-1:0] data,
  output logic          misaligned
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Big-endian lanes: offset 0 is the most significant byte.
  always_comb begin
    byte_v = mem[31:24];
    case (off)
      2'd0:    byte_v = mem[31:24];
      2'd1:    byte_v = mem[23:16];
      2'd2:    byte_v = mem[15:8];
      default: byte_v = mem[7:0];
    endcase
    half_v = off[1] ? mem[15:0] : mem[31:16];
  end

  always_comb begin
    data       = mem;
    misaligned = 1'b0;
    case (ldtype)
      LD_H: begin
        data       = {{(DW-16){half_v[15]}}, half_v};
        misaligned = off[0];
      end
      LD_HU: begin
        data       = {{(DW-16){1'b0}}, half_v};
        misaligned = off[0];
      end
      LD_B:  data = {{(DW-8){byte_v[7]}}, byte_v};
      LD_BU: data = {{(DW-8){1'b0}}, byte_v};
      default: begin
        data       = mem;
        misaligned = (off != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: MIPS write-back stage. Registers the MEM/WB bundle, selects the
// result (ALU, aligned load data, PC+8 link) and drives the register bank
// write port. Writes to r0 and misaligned loads are suppressed; a stalled
// entry is written only in its first cycle.
//   clk, R (sync active-high reset), stall, flush
//   in_*      MEM/WB bundle from the memory stage
//   AdrC/C/W  register bank write port (decoded from the stage register)
//   misalign  pulse when the presented load is misaligned and dropped
//   retired   count of valid entries completed
// Optional macro WB_FWD_EN adds fwd_valid/fwd_adr/fwd_data bypass outputs
// that stay valid through held stall cycles.
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic          clk,
  input  logic          R,
  input  logic          stall,
  input  logic          flush,
  input  logic          in_valid,
  input  logic          in_regwrite,
  input  logic [AW-1:0] in_rd,
  input  logic [1:0]    in_sel,
  input  logic [2:0]    in_ldtype,
  input  logic [DW-1:0] in_alu,
  input  logic [DW-1:0] in_mem,
  input  logic [DW-1:0] in_pc,
  output logic [AW-1:0] AdrC,
  output logic [DW-1:0] C,
  output logic          W,
  output logic          misalign,
`ifdef WB_FWD_EN
  output logic          fwd_valid,
  output logic [AW-1:0] fwd_adr,
  output logic [DW-1:0] fwd_data,
`endif
  output logic [31:0]   retired
);

  wb_entry_t     entry;
  logic          done;
  logic          live;
  logic [DW-1:0] ld_data;
  logic          ld_mis;
  logic          mis_ld;
  logic          wr_ok;

  // Entry is presented for the first time this cycle.
  assign live = entry.valid & ~done;

  // Stage register and retirement counter; reset > flush > stall > capture.
  always_ff @(posedge clk) begin
    if (R) begin
      entry   <= '0;
      done    <= 1'b0;
      retired <= '0;
    end else begin
      retired <= retired + 32'(live);
      if (flush) begin
        entry.valid <= 1'b0;
        done        <= 1'b0;
      end else if (stall) begin
        if (entry.valid) done <= 1'b1;
      end else begin
        entry <= '{valid:    in_valid,
                   regwrite: in_regwrite,
                   rd:       in_rd,
                   sel:      in_sel,
                   ldtype:   in_ldtype,
                   alu:      in_alu,
                   mem:      in_mem,
                   pc:       in_pc};
        done  <= 1'b0;
      end
    end
  end

  load_align u_align (
    .ldtype     (entry.ldtype),
    .off        (entry.alu[1:0]),
    .mem        (entry.mem),
    .data       (ld_data),
    .misaligned (ld_mis)
  );

  assign mis_ld = (entry.sel == SEL_LOAD) & ld_mis;
  assign wr_ok  = entry.valid & entry.regwrite & (entry.rd != '0) & ~mis_ld;

  // Result select and write-port decode.
  always_comb begin
    C = entry.alu;
    case (entry.sel)
      SEL_LOAD: C = ld_data;
      SEL_LINK: C = entry.pc + DW'(LINK_OFFSET);
      default:  C = entry.alu;
    endcase
    AdrC     = entry.rd;
    W        = wr_ok & ~done;
    misalign = live & mis_ld & entry.regwrite;
  end

`ifdef WB_FWD_EN
  // Bypass copy that remains valid while the entry is held.
  assign fwd_valid = wr_ok;
  assign fwd_adr   = AdrC;
  assign fwd_data  = C;
`endif

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
  import wb_stage_pkg::*;

  logic          clk = 1'b0;
  logic          R, stall, flush, in_valid, in_regwrite;
  logic [AW-1:0] in_rd;
  logic [1:0]    in_sel;
  logic [2:0]    in_ldtype;
  logic [DW-1:0] in_alu, in_mem, in_pc;
  logic [AW-1:0] AdrC;
  logic [DW-1:0] C;
  logic          W, misalign;
  logic [31:0]   retired;
`ifdef WB_FWD_EN
  logic          fwd_valid;
  logic [AW-1:0] fwd_adr;
  logic [DW-1:0] fwd_data;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_ret;
  bit          m_live;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .R(R), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_regwrite(in_regwrite), .in_rd(in_rd),
    .in_sel(in_sel), .in_ldtype(in_ldtype), .in_alu(in_alu),
    .in_mem(in_mem), .in_pc(in_pc),
    .AdrC(AdrC), .C(C), .W(W), .misalign(misalign),
`ifdef WB_FWD_EN
    .fwd_valid(fwd_valid), .fwd_adr(fwd_adr), .fwd_data(fwd_data),
`endif
    .retired(retired)
  );

  typedef struct {
    logic        rw;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [2:0]  ldt;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] pc;
    logic        exp_w;
    logic [31:0] exp_c;
    bit          chk_c;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, update the retirement model at posedge, settle.
  task automatic cyc(input logic r, input logic st, input logic fl, input logic v,
                     input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                     input logic [2:0] ldt, input logic [31:0] alu,
                     input logic [31:0] mem, input logic [31:0] pc);
    @(negedge clk);
    R = r; stall = st; flush = fl; in_valid = v; in_regwrite = rw; in_rd = rd;
    in_sel = sel; in_ldtype = ldt; in_alu = alu; in_mem = mem; in_pc = pc;
    @(posedge clk);
    if (r) begin
      exp_ret = '0; m_live = 1'b0;
    end else begin
      exp_ret = exp_ret + 32'(m_live);
      if (fl || st) m_live = 1'b0;
      else          m_live = v;
    end
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] r_snap;
    exp_ret = '0; m_live = 1'b0;

    //         rw  rd     sel    ldt     alu           mem           pc            W     C             chkC mis
    vecs[0]  = '{1'b1, 5'd5,  2'b00, 3'b000, 32'h12345678, 32'h0,        32'h0,        1'b1, 32'h12345678, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 5'd6,  2'b01, 3'b011, 32'h00001001, 32'h11F23344, 32'h0,        1'b1, 32'hFFFFFFF2, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 5'd7,  2'b01, 3'b100, 32'h00001001, 32'h11F23344, 32'h0,        1'b1, 32'h000000F2, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 5'd8,  2'b01, 3'b010, 32'h00001002, 32'h0000ABCD, 32'h0,        1'b1, 32'h0000ABCD, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 5'd9,  2'b01, 3'b001, 32'h00001000, 32'h80011234, 32'h0,        1'b1, 32'hFFFF8001, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 5'd10, 2'b01, 3'b011, 32'h00001003, 32'h11F23344, 32'h0,        1'b1, 32'h00000044, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 5'd11, 2'b01, 3'b000, 32'h00001002, 32'hDEADBEEF, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1};
    vecs[7]  = '{1'b1, 5'd0,  2'b00, 3'b000, 32'h00000099, 32'h0,        32'h0,        1'b0, 32'h0,        1'b0, 1'b0};
    vecs[8]  = '{1'b1, 5'd31, 2'b10, 3'b000, 32'h0,        32'h0,        32'h00400010, 1'b1, 32'h00400018, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 5'd12, 2'b11, 3'b000, 32'hCAFEF00D, 32'h0,        32'h0,        1'b1, 32'hCAFEF00D, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 5'd13, 2'b01, 3'b001, 32'h00001001, 32'h12345678, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1};
    vecs[11] = '{1'b1, 5'd13, 2'b01, 3'b000, 32'h00002000, 32'hA5A50F0F, 32'h0,        1'b1, 32'hA5A50F0F, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 5'd14, 2'b01, 3'b000, 32'h00002001, 32'h0,        32'h0,        1'b0, 32'h0,        1'b0, 1'b0};
    vecs[13] = '{1'b1, 5'd14, 2'b01, 3'b111, 32'h00002004, 32'h01020304, 32'h0,        1'b1, 32'h01020304, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 5'd15, 2'b01, 3'b010, 32'h00001000, 32'hFEDC1234, 32'h0,        1'b1, 32'h0000FEDC, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 5'd16, 2'b10, 3'b000, 32'h0,        32'h0,        32'hFFFFFFFC, 1'b1, 32'h00000004, 1'b1, 1'b0};
    vecs[16] = '{1'b1, 5'd20, 2'b00, 3'b000, 32'h00000001, 32'h0,        32'h0,        1'b1, 32'h00000001, 1'b1, 1'b0};
    vecs[17] = '{1'b1, 5'd20, 2'b00, 3'b000, 32'h00000002, 32'h0,        32'h0,        1'b1, 32'h00000002, 1'b1, 1'b0};

    // Reset for two cycles, then release.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 2'b00, 3'd0, 32'h55, 32'h0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 2'b00, 3'd0, 32'h55, 32'h0, 32'h0);
    chk("rst_adrc", 32'(AdrC), 32'h0);
    chk("rst_c", C, 32'h0);
    chk("rst_w", 32'(W), 32'h0);
    chk("rst_mis", 32'(misalign), 32'h0);
    chk("rst_retired", retired, 32'h0);
    idle();
    chk("idle_w", 32'(W), 32'h0);
    chk("idle_retired", retired, 32'h0);

    // Back-to-back vectors, one per cycle.
    for (int i = 0; i < 18; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1, vecs[i].rw, vecs[i].rd, vecs[i].sel, vecs[i].ldt,
          vecs[i].alu, vecs[i].mem, vecs[i].pc);
      chk($sformatf("v%0d_w", i), 32'(W), 32'(vecs[i].exp_w));
      chk($sformatf("v%0d_adrc", i), 32'(AdrC), 32'(vecs[i].rd));
      chk($sformatf("v%0d_mis", i), 32'(misalign), 32'(vecs[i].exp_mis));
      if (vecs[i].chk_c) chk($sformatf("v%0d_c", i), C, vecs[i].exp_c);
      chk($sformatf("v%0d_retired", i), retired, exp_ret);
      chk($sformatf("v%0d_retired_abs", i), retired, 32'(i));
    end
    idle();
    chk("loop_retired", retired, 32'd18);
    chk("loop_idle_mis", 32'(misalign), 32'h0);

    // Link entry held by a 3-cycle stall: written once, retired once.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd31, 2'b10, 3'd0, 32'h0, 32'h0, 32'h00400010);
    r_snap = retired;
    chk("stl_w0", 32'(W), 32'h1);
    chk("stl_c0", C, 32'h00400018);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 2'b00, 3'd0, 32'hBAD, 32'h0, 32'h0);
      chk($sformatf("stl%0d_w", k), 32'(W), 32'h0);
      chk($sformatf("stl%0d_adrc", k), 32'(AdrC), 32'd31);
      chk($sformatf("stl%0d_retired", k), retired, r_snap + 32'd1);
`ifdef WB_FWD_EN
      chk($sformatf("stl%0d_fwd_valid", k), 32'(fwd_valid), 32'h1);
      chk($sformatf("stl%0d_fwd_data", k), fwd_data, 32'h00400018);
`endif
    end
    idle();
    chk("stl_end_w", 32'(W), 32'h0);
    chk("stl_end_retired", retired, r_snap + 32'd1);

    // flush and stall together with a valid input: bubble loaded.
    r_snap = retired;
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd4, 2'b00, 3'd0, 32'h77, 32'h0, 32'h0);
    chk("fls_w", 32'(W), 32'h0);
    idle();
    chk("fls_retired", retired, r_snap);
    chk("fls_model", retired, exp_ret);

    // Reset asserted during a stall discards the entry.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd6, 2'b00, 3'd0, 32'h66, 32'h0, 32'h0);
    chk("rms_w_pre", 32'(W), 32'h1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 2'b00, 3'd0, 32'h66, 32'h0, 32'h0);
    chk("rms_w", 32'(W), 32'h0);
    chk("rms_retired", retired, 32'h0);
    idle();
    chk("rms_w_after", 32'(W), 32'h0);
    chk("rms_retired_after", retired, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
